// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the multiplexer channel scanner.
package mux_scan_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRIVE,
      S_CAPTURE,
      S_WAIT,
      S_DONE
   } scan_state_t;

   localparam int NUM_CH   = 4;
   localparam int SEL_W    = 2;
   localparam int SETTLE_W = 4;

endpackage

// File: rtl/rate_divider.sv
// Load/decrement dwell counter with a zero flag; reloaded on every WAIT entry.
module rate_divider
   import mux_scan_pkg::*;
#(
   parameter int DIV_WIDTH = 26
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 load,
   input  logic                 dec,
   input  logic [DIV_WIDTH-1:0] load_val,
   output logic                 zero
);

   logic [DIV_WIDTH-1:0] count;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/mux_channel_scanner.sv
// Steps the 4:1 mux select through every channel, captures each settled output
// bit and publishes the 4-bit word with a one-cycle valid strobe.
module mux_channel_scanner
   import mux_scan_pkg::*;
#(
   parameter int SETTLE    = 1,
   parameter int DIV_WIDTH = 26
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 mode,
   input  logic                 start,
   input  logic [DIV_WIDTH-1:0] rate_max,
   input  logic                 mux_out,
   output logic [SEL_W-1:0]     sel,
   output logic [NUM_CH-1:0]    sample,
   output logic                 sample_valid,
   output logic                 busy
);

   localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(SETTLE - 1);
   localparam logic [SEL_W-1:0]    LAST_CH     = SEL_W'(NUM_CH - 1);

   scan_state_t          state, state_next;
   logic [SETTLE_W-1:0]  settle_cnt;
   logic [NUM_CH-1:0]    shadow, shadow_next;
   logic [SEL_W-1:0]     sel_next;
   logic                 settle_load, settle_dec;
   logic                 dwell_load, dwell_dec, dwell_zero;
   logic                 capture, last_ch, auto_go;

   assign last_ch = (sel == LAST_CH);
   assign auto_go = ~mode & enable;

   rate_divider #(
      .DIV_WIDTH (DIV_WIDTH)
   ) u_dwell (
      .clock    (clock),
      .reset    (reset),
      .load     (dwell_load),
      .dec      (dwell_dec),
      .load_val (rate_max),
      .zero     (dwell_zero)
   );

   always_comb begin
      state_next  = state;
      sel_next    = sel;
      settle_load = 1'b0;
      settle_dec  = 1'b0;
      dwell_load  = 1'b0;
      dwell_dec   = 1'b0;
      capture     = 1'b0;
      case (state)
         S_IDLE: begin
            if (auto_go || (mode && start)) begin
               state_next  = S_DRIVE;
               sel_next    = '0;
               settle_load = 1'b1;
            end
         end
         S_DRIVE: begin
            if (settle_cnt == '0) begin
               state_next = S_CAPTURE;
            end else begin
               settle_dec = 1'b1;
            end
         end
         S_CAPTURE: begin
            capture = 1'b1;
            if (last_ch) begin
               state_next = S_DONE;
            end else begin
               state_next = S_WAIT;
               dwell_load = 1'b1;
            end
         end
         S_WAIT: begin
            if (dwell_zero) begin
               state_next  = S_DRIVE;
               sel_next    = sel + 1'b1;
               settle_load = 1'b1;
            end else begin
               dwell_dec = 1'b1;
            end
         end
         S_DONE: begin
            // mode/enable are only consulted here, so a running sweep always completes
            if (auto_go) begin
               state_next  = S_DRIVE;
               sel_next    = '0;
               settle_load = 1'b1;
            end else begin
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      shadow_next = shadow;
      if (capture) begin
         shadow_next[sel] = mux_out;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         sel          <= '0;
         settle_cnt   <= '0;
         shadow       <= '0;
         sample       <= '0;
         sample_valid <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state <= state_next;
         sel   <= sel_next;
         if (settle_load) begin
            settle_cnt <= SETTLE_INIT;
         end else if (settle_dec) begin
            settle_cnt <= settle_cnt - 1'b1;
         end
         shadow <= shadow_next;
         // the last channel's bit is merged on the same edge that publishes the word
         if (capture && last_ch) begin
            sample <= shadow_next;
         end
         sample_valid <= capture & last_ch;
         busy         <= (state_next != S_IDLE);
      end
   end

endmodule

// File: tb/tb_mux_channel_scanner.sv
// Bench for mux_channel_scanner: two instances (SETTLE=1 and SETTLE=3 with a
// glitching mux) checked every cycle against a sweep-schedule model.
module tb_mux_channel_scanner;

   localparam int DW = 8;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          enable = 1'b0;
   logic          mode = 1'b1;
   logic          start = 1'b0;
   logic [DW-1:0] rate_max = '0;
   logic [3:0]    pat = 4'b0000;
   logic          mux0, mux1;
   logic [1:0]    sel0, sel1;
   logic [3:0]    sample0, sample1;
   logic          valid0, valid1, busy0, busy1;
   logic [1:0]    psel1 = 2'd0;
   int            age1 = 100;
   int            n_tests = 0;
   int            n_fail = 0;
   bit            chk_en = 1'b0;

   always #5 clock = ~clock;

   mux_channel_scanner #(.SETTLE(1), .DIV_WIDTH(DW)) dut0 (
      .clock(clock), .reset(reset), .enable(enable), .mode(mode), .start(start),
      .rate_max(rate_max), .mux_out(mux0), .sel(sel0), .sample(sample0),
      .sample_valid(valid0), .busy(busy0)
   );

   mux_channel_scanner #(.SETTLE(3), .DIV_WIDTH(DW)) dut1 (
      .clock(clock), .reset(reset), .enable(enable), .mode(mode), .start(start),
      .rate_max(rate_max), .mux_out(mux1), .sel(sel1), .sample(sample1),
      .sample_valid(valid1), .busy(busy1)
   );

   // instance 1 sees the wrong mux value for 2 cycles after every select change
   assign mux0 = pat[sel0];
   assign mux1 = pat[sel1] ^ (age1 < 2);

   always @(negedge clock) begin
      if (sel1 != psel1) age1 <= 0;
      else if (age1 < 100) age1 <= age1 + 1;
      psel1 <= sel1;
   end

   // Schedule model: t counts edges since the trigger edge; channel k owns
   // t in [k*P, (k+1)*P), its capture edge is k*P+S+1, the word lands at 3P+S+1.
   int         m_t[2];
   bit         m_act[2];
   logic [3:0] m_cap[2];
   logic [1:0] m_sel[2];
   logic [3:0] m_sample[2];
   logic       m_valid[2];

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 2; i++) begin
            m_t[i] <= 0;
            m_act[i] <= 1'b0;
            m_cap[i] <= 4'b0;
            m_sel[i] <= 2'd0;
            m_sample[i] <= 4'b0;
            m_valid[i] <= 1'b0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            automatic int         s   = (i == 0) ? 1 : 3;
            automatic int         p   = s + 2 + int'(rate_max);
            automatic int         u   = 3 * p + s + 1;
            automatic int         t   = m_t[i];
            automatic bit         act = m_act[i];
            automatic logic [3:0] cap = m_cap[i];
            automatic logic [3:0] smp = m_sample[i];
            automatic logic [1:0] sl  = m_sel[i];
            automatic logic       vld = 1'b0;
            if (act) begin
               t = t + 1;
               for (int k = 0; k < 4; k++) begin
                  if (t == k * p + s + 1) cap[k] = pat[k];
               end
               if (t == u) begin
                  smp = cap;
                  vld = 1'b1;
               end else if (t == u + 1) begin
                  if (!mode && enable) t = 0;
                  else act = 1'b0;
               end
            end else if ((!mode && enable) || (mode && start)) begin
               act = 1'b1;
               t = 0;
            end
            if (act) sl = (t / p > 3) ? 2'd3 : 2'(t / p);
            m_t[i] <= t;
            m_act[i] <= act;
            m_cap[i] <= cap;
            m_sel[i] <= sl;
            m_sample[i] <= smp;
            m_valid[i] <= vld;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      if (chk_en) begin
         check("sel0", sel0, m_sel[0]);
         check("sample0", sample0, m_sample[0]);
         check("valid0", valid0, m_valid[0]);
         check("busy0", busy0, m_act[0]);
         check("sel1", sel1, m_sel[1]);
         check("sample1", sample1, m_sample[1]);
         check("valid1", valid1, m_valid[1]);
         check("busy1", busy1, m_act[1]);
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   initial begin
      int f0, f1, c0, c1, a0, b0, a1, b1, w;
      #1 reset = 1'b1;
      @(negedge clock);
      chk_en = 1'b1;
      cycles(2);
      reset = 1'b0;
      cycles(3);

      // asynchronous reset in the middle of a sweep
      pat = 4'b1111;
      mode = 1'b1;
      pulse_start();
      cycles(20);
      pulse_start();
      cycles(7);
      @(posedge clock);
      #2 reset = 1'b1;
      #1;
      check("rst_sel0", sel0, 0);
      check("rst_sample0", sample0, 0);
      check("rst_valid0", valid0, 0);
      check("rst_busy0", busy0, 0);
      check("rst_sample1", sample1, 0);
      check("rst_busy1", busy1, 0);
      @(negedge clock);
      reset = 1'b0;
      cycles(2);

      // single-shot with defaults: pattern 1,0,1,1 on channels 0..3
      pat = 4'b1101;
      rate_max = '0;
      pulse_start();
      f0 = -1; f1 = -1; c0 = 0; c1 = 0;
      for (int n = 1; n <= 30; n++) begin
         @(negedge clock);
         if (valid0) begin c0++; if (f0 < 0) f0 = n; end
         if (valid1) begin c1++; if (f1 < 0) f1 = n; end
      end
      check("ss_edge0", f0, 11);
      check("ss_edge1", f1, 19);
      check("ss_strobes0", c0, 1);
      check("ss_strobes1", c1, 1);
      check("ss_busy0", busy0, 0);
      check("ss_sel0", sel0, 3);
      check("ss_word0", sample0, 4'b1101);
      check("ss_word1", sample1, 4'b1101);

      // auto mode with three-cycle dwell, then enable dropped during channel 1
      rate_max = DW'(2);
      mode = 1'b0;
      enable = 1'b1;
      @(negedge clock);
      a0 = -1; b0 = -1; a1 = -1; b1 = -1;
      for (int n = 1; n <= 60; n++) begin
         @(negedge clock);
         if (valid0) begin if (a0 < 0) a0 = n; else if (b0 < 0) b0 = n; end
         if (valid1) begin if (a1 < 0) a1 = n; else if (b1 < 0) b1 = n; end
      end
      check("auto_first0", a0, 17);
      check("auto_period0", b0 - a0, 18);
      check("auto_first1", a1, 25);
      check("auto_period1", b1 - a1, 26);
      w = 0;
      while (sel0 != 2'd1 && w < 40) begin @(negedge clock); w++; end
      check("auto_reach_ch1", (w < 40), 1);
      enable = 1'b0;
      c0 = 0;
      for (int n = 0; n < 60; n++) begin
         @(negedge clock);
         if (valid0) c0++;
      end
      check("auto_tail_strobes0", c0, 1);
      check("auto_idle0", busy0, 0);

      // second start while busy is ignored
      mode = 1'b1;
      rate_max = '0;
      pulse_start();
      w = 0;
      while (sel0 != 2'd2 && w < 20) begin @(negedge clock); w++; end
      check("busy_reach_ch2", (w < 20), 1);
      pulse_start();
      c0 = 0; c1 = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clock);
         if (valid0) c0++;
         if (valid1) c1++;
      end
      check("busy_strobes0", c0, 1);
      check("busy_strobes1", c1, 1);

      // reset during channel-2 capture discards the partial word
      pat = 4'b1010;
      pulse_start();
      cycles(25);
      check("pre_word0", sample0, 4'b1010);
      check("pre_word1", sample1, 4'b1010);
      pat = 4'b0110;
      pulse_start();
      cycles(7);
      reset = 1'b1;
      #1;
      check("midrst_sample0", sample0, 0);
      check("midrst_sample1", sample1, 0);
      check("midrst_busy0", busy0, 0);
      @(negedge clock);
      reset = 1'b0;
      pulse_start();
      cycles(25);
      check("post_word0", sample0, 4'b0110);
      check("post_word1", sample1, 4'b0110);

      // randomized traffic against the model
      for (int c = 0; c < 1500; c++) begin
         @(negedge clock);
         if ($urandom_range(0, 7) == 0) enable = ~enable;
         if ($urandom_range(0, 15) == 0) mode = ~mode;
         start = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 6) == 0) pat = 4'($urandom);
         if (!busy0 && !busy1) rate_max = DW'($urandom_range(0, 3));
         reset = ($urandom_range(0, 299) == 0);
      end
      @(negedge clock);
      reset = 1'b0;
      enable = 1'b0;
      start = 1'b0;
      cycles(3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
